// File: rtl/char_grid_pkg.sv
// Shared defaults and FSM state type for the character grid text buffer.
package char_grid_pkg;

    localparam int DEF_CHAR_W = 6;
    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 48;
    localparam int DEF_CELL_W = 8;
    localparam int DEF_CELL_H = 10;
    localparam int DEF_FILL   = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/char_grid_if.sv
// Pixel-lookup and write-port bundle of the character grid; master drives, slave is the grid.
interface char_grid_if
    import char_grid_pkg::*;
#(
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int CELL_W = DEF_CELL_W,
    parameter int CELL_H = DEF_CELL_H
) ();

    logic [9:0]                xcoor;
    logic [8:0]                ycoor;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [$clog2(COLS)-1:0]   wr_col;
    logic [$clog2(ROWS)-1:0]   wr_row;
    logic [CHAR_W-1:0]         wr_char;
    logic                      clear_req;
    logic                      busy;
    logic [CHAR_W-1:0]         char_out;
    logic [$clog2(CELL_W)-1:0] cell_x;
    logic [$clog2(CELL_H)-1:0] cell_y;

    modport master (
        output xcoor, ycoor, wr_valid, wr_col, wr_row, wr_char, clear_req,
        input  wr_ready, busy, char_out, cell_x, cell_y
    );

    modport slave (
        input  xcoor, ycoor, wr_valid, wr_col, wr_row, wr_char, clear_req,
        output wr_ready, busy, char_out, cell_x, cell_y
    );

endinterface

// File: rtl/char_grid_ram.sv
// Simple dual-port code store: one synchronous write port, one synchronous read port, no reset.
module char_grid_ram #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 3840,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // A read hitting the cell being written returns the old contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/char_grid.sv
// Character-cell text buffer: maps a pixel coordinate to the stored code in two stages
// and clears the whole grid one cell per cycle after reset or on request.
module char_grid
    import char_grid_pkg::*;
#(
    parameter int                CHAR_W = DEF_CHAR_W,
    parameter int                COLS   = DEF_COLS,
    parameter int                ROWS   = DEF_ROWS,
    parameter int                CELL_W = DEF_CELL_W,
    parameter int                CELL_H = DEF_CELL_H,
    parameter logic [CHAR_W-1:0] FILL   = CHAR_W'(DEF_FILL),
    parameter logic [CHAR_W-1:0] BLANK  = '1
) (
    input  logic       clk,
    input  logic       rst_n,
    char_grid_if.slave bus
);

    localparam int CX_W   = $clog2(CELL_W);
    localparam int CY_W   = $clog2(CELL_H);
    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = $clog2(DEPTH);

    logic [9:0]        w_colFull;
    logic [8:0]        w_rowFull;
    logic [CX_W-1:0]   w_cx;
    logic [CY_W-1:0]   w_cy;
    logic              w_inGrid;
    logic [ADDR_W-1:0] w_rdAddr;

    logic [ADDR_W-1:0] r_rdAddr;
    logic [CX_W-1:0]   r_cx1;
    logic [CY_W-1:0]   r_cy1;
    logic              r_inGrid1;
    logic [CX_W-1:0]   r_cx2;
    logic [CY_W-1:0]   r_cy2;
    logic              r_inGrid2;
    logic [CHAR_W-1:0] w_ramData;

    state_t            r_state;
    logic [ADDR_W-1:0] r_sweepAddr;
    logic              r_busy;
    logic              r_wrReady;

    logic              w_wrInRange;
    logic              w_userWe;
    logic [ADDR_W-1:0] w_wrAddr;
    logic              w_ramWe;
    logic [ADDR_W-1:0] w_ramWaddr;
    logic [CHAR_W-1:0] w_ramWdata;

    assign w_colFull = bus.xcoor / 10'(CELL_W);
    assign w_rowFull = bus.ycoor / 9'(CELL_H);
    assign w_cx      = CX_W'(bus.xcoor % 10'(CELL_W));
    assign w_cy      = CY_W'(bus.ycoor % 9'(CELL_H));
    assign w_inGrid  = (int'(w_colFull) < COLS) && (int'(w_rowFull) < ROWS);
    assign w_rdAddr  = w_inGrid ? ADDR_W'(int'(w_rowFull) * COLS + int'(w_colFull)) : '0;

    // Stage 1 holds the cell address and in-cell offsets; stage 2 aligns offsets with RAM data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdAddr  <= '0;
            r_cx1     <= '0;
            r_cy1     <= '0;
            r_inGrid1 <= 1'b0;
            r_cx2     <= '0;
            r_cy2     <= '0;
            r_inGrid2 <= 1'b0;
        end else begin
            r_rdAddr  <= w_rdAddr;
            r_cx1     <= w_cx;
            r_cy1     <= w_cy;
            r_inGrid1 <= w_inGrid;
            r_cx2     <= r_cx1;
            r_cy2     <= r_cy1;
            r_inGrid2 <= r_inGrid1;
        end
    end

    assign w_wrInRange = (int'(bus.wr_col) < COLS) && (int'(bus.wr_row) < ROWS);
    assign w_userWe    = rst_n && bus.wr_valid && r_wrReady && w_wrInRange;
    assign w_wrAddr    = ADDR_W'(int'(bus.wr_row) * COLS + int'(bus.wr_col));

    assign w_ramWe    = (r_state == ST_CLEAR) || w_userWe;
    assign w_ramWaddr = (r_state == ST_CLEAR) ? r_sweepAddr : w_wrAddr;
    assign w_ramWdata = (r_state == ST_CLEAR) ? FILL : bus.wr_char;

    // Reset parks the FSM in CLEAR so the memory is swept instead of reset in parallel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_sweepAddr <= '0;
            r_busy      <= 1'b1;
            r_wrReady   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        r_state     <= ST_CLEAR;
                        r_sweepAddr <= '0;
                        r_busy      <= 1'b1;
                        r_wrReady   <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_sweepAddr == ADDR_W'(DEPTH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_sweepAddr <= '0;
                        r_busy      <= 1'b0;
                        r_wrReady   <= 1'b1;
                    end else begin
                        r_sweepAddr <= r_sweepAddr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_sweepAddr <= '0;
                    r_busy      <= 1'b1;
                    r_wrReady   <= 1'b0;
                end
            endcase
        end
    end

    char_grid_ram #(
        .DATA_W (CHAR_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ramWe),
        .i_waddr (w_ramWaddr),
        .i_wdata (w_ramWdata),
        .i_raddr (r_rdAddr),
        .o_rdata (w_ramData)
    );

    assign bus.char_out = r_inGrid2 ? w_ramData : BLANK;
    assign bus.cell_x   = r_cx2;
    assign bus.cell_y   = r_cy2;
    assign bus.busy     = r_busy;
    assign bus.wr_ready = r_wrReady;

endmodule

// File: tb/tb_char_grid.sv
// Self-checking bench for char_grid: constant vector table, hand-built sweep/reset sequences,
// and randomized traffic compared against an array model of the grid.
module tb_char_grid;
    import char_grid_pkg::*;

    localparam int COLS   = 80;
    localparam int ROWS   = 48;
    localparam int CELL_W = 8;
    localparam int CELL_H = 10;
    localparam int NCELL  = COLS * ROWS;
    localparam int BLANK  = 'h3F;

    typedef struct {
        int x;
        int y;
        int expChar;
        int expCx;
        int expCy;
    } vec_t;

    typedef struct {
        int ch;
        int cx;
        int cy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   refMem [NCELL];
    vec_t vecs [12];

    always #5 clk = ~clk;

    char_grid_if busA ();
    char_grid_if #(.ROWS(40)) busB ();

    char_grid dut (.clk(clk), .rst_n(rst_n), .bus(busA.slave));
    char_grid #(.ROWS(40)) dut40 (.clk(clk), .rst_n(rst_n), .bus(busB.slave));

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkVal(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        checkVal({name, ".char"}, int'(busA.char_out), e.ch);
        checkVal({name, ".cellX"}, int'(busA.cell_x), e.cx);
        checkVal({name, ".cellY"}, int'(busA.cell_y), e.cy);
    endtask

    function automatic exp_t refRead(input int x, input int y);
        exp_t e;
        int col = x / CELL_W;
        int row = y / CELL_H;
        e.cx = x % CELL_W;
        e.cy = y % CELL_H;
        e.ch = (col < COLS && row < ROWS) ? refMem[row * COLS + col] : BLANK;
        return e;
    endfunction

    function automatic void clearModel();
        foreach (refMem[i]) refMem[i] = 0;
    endfunction

    task automatic applyStimulus(input int x, input int y);
        busA.xcoor = 10'(x);
        busA.ycoor = 9'(y);
    endtask

    task automatic readExpect(input string name, input int x, input int y);
        applyStimulus(x, y);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput(name, refRead(x, y));
    endtask

    task automatic doWrite(input int col, input int row, input int ch);
        bit accepted;
        busA.wr_valid = 1'b1;
        busA.wr_col   = 7'(col);
        busA.wr_row   = 6'(row);
        busA.wr_char  = 6'(ch);
        accepted = busA.wr_ready;
        @(negedge clk);
        busA.wr_valid = 1'b0;
        if (accepted && col < COLS && row < ROWS) refMem[row * COLS + col] = ch;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busA.busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Output seen after edge j-1 belongs to the sample driven before edge j-2, read against
    // memory holding every write accepted up to and including that same edge.
    task automatic runRandom(input int n);
        exp_t q [$];
        exp_t e;
        int   px = 0, py = 0, pc = 0, pr = 0, pch = 0;
        bit   pv = 0, pacc = 0;
        for (int j = 0; j <= n; j++) begin
            if (pv && pacc && pc < COLS && pr < ROWS) refMem[pr * COLS + pc] = pch;
            if (j >= 2) begin
                e = q.pop_front();
                checkOutput("random", e);
            end
            if (j >= 1) q.push_back(refRead(px, py));
            if (j < n) begin
                px  = int'($urandom_range(0, 700));
                py  = int'($urandom_range(0, 500));
                pv  = ($urandom_range(0, 2) != 0);
                pc  = int'($urandom_range(0, 84));
                pr  = int'($urandom_range(0, 51));
                pch = int'($urandom_range(0, 63));
                applyStimulus(px, py);
                busA.wr_valid = pv;
                busA.wr_col   = 7'(pc);
                busA.wr_row   = 6'(pr);
                busA.wr_char  = 6'(pch);
                pacc = busA.wr_ready;
            end else begin
                pv = 1'b0;
                busA.wr_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        exp_t e;

        applyStimulus(100, 100);
        busA.wr_valid  = 1'b0;
        busA.wr_col    = '0;
        busA.wr_row    = '0;
        busA.wr_char   = '0;
        busA.clear_req = 1'b0;
        busB.xcoor     = '0;
        busB.ycoor     = '0;
        busB.wr_valid  = 1'b0;
        busB.wr_col    = '0;
        busB.wr_row    = '0;
        busB.wr_char   = '0;
        busB.clear_req = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("resetChar", int'(busA.char_out), BLANK);
        checkVal("resetCellX", int'(busA.cell_x), 0);
        checkVal("resetCellY", int'(busA.cell_y), 0);
        checkVal("resetBusy", int'(busA.busy), 1);
        checkVal("resetReady", int'(busA.wr_ready), 0);

        rst_n = 1'b1;
        countBusy(n);
        checkVal("resetSweepLen", n, NCELL);
        checkVal("readyAfterSweep", int'(busA.wr_ready), 1);
        clearModel();
        readExpect("origin", 0, 0);

        doWrite(5, 2, 'h2A);
        doWrite(79, 47, 'h15);

        vecs[0]  = '{40, 20, 'h2A, 0, 0};
        vecs[1]  = '{47, 29, 'h2A, 7, 9};
        vecs[2]  = '{43, 25, 'h2A, 3, 5};
        vecs[3]  = '{45, 21, 'h2A, 5, 1};
        vecs[4]  = '{48, 20, 0, 0, 0};
        vecs[5]  = '{39, 20, 0, 7, 0};
        vecs[6]  = '{40, 30, 0, 0, 0};
        vecs[7]  = '{639, 479, 'h15, 7, 9};
        vecs[8]  = '{632, 470, 'h15, 0, 0};
        vecs[9]  = '{700, 10, BLANK, 4, 0};
        vecs[10] = '{10, 480, BLANK, 2, 0};
        vecs[11] = '{1023, 511, BLANK, 7, 1};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y);
            repeat (2) @(posedge clk);
            @(negedge clk);
            e = '{vecs[i].expChar, vecs[i].expCx, vecs[i].expCy};
            checkOutput($sformatf("vec%0d", i), e);
        end

        for (int y = 20; y < 30; y++) begin
            for (int x = 40; x < 48; x++) begin
                applyStimulus(x, y);
                repeat (2) @(posedge clk);
                @(negedge clk);
                e = '{'h2A, x - 40, y - 20};
                checkOutput("cell52", e);
            end
        end

        // The write lands on the edge where the held (3,1) address is being read from RAM.
        applyStimulus(24, 10);
        @(posedge clk);
        @(negedge clk);
        busA.wr_valid = 1'b1;
        busA.wr_col   = 7'(3);
        busA.wr_row   = 6'(1);
        busA.wr_char  = 6'h11;
        @(posedge clk);
        @(negedge clk);
        busA.wr_valid = 1'b0;
        checkVal("rbwOld", int'(busA.char_out), 0);
        refMem[1 * COLS + 3] = 'h11;
        @(posedge clk);
        @(negedge clk);
        checkVal("rbwNew", int'(busA.char_out), 'h11);

        checkVal("badColReady", int'(busA.wr_ready), 1);
        doWrite(80, 0, 'h33);
        readExpect("badColNoWrite", 0, 10);
        checkVal("badColCell", int'(busA.char_out), 0);

        runRandom(300);

        busA.wr_valid  = 1'b1;
        busA.wr_col    = 7'(79);
        busA.wr_row    = 6'(47);
        busA.wr_char   = 6'h22;
        busA.clear_req = 1'b1;
        @(negedge clk);
        busA.wr_valid  = 1'b0;
        busA.clear_req = 1'b0;
        checkVal("clearStartBusy", int'(busA.busy), 1);
        n = 0;
        while (busA.busy && n < 5000) begin
            n++;
            if (n == 5) applyStimulus(40, 20);
            if (n == 8) checkVal("readDuringClear", int'(busA.char_out), refMem[2 * COLS + 5]);
            if (n == 100) begin
                busA.wr_valid = 1'b1;
                busA.wr_col   = 7'(79);
                busA.wr_row   = 6'(47);
                busA.wr_char  = 6'h07;
                checkVal("readyLowInClear", int'(busA.wr_ready), 0);
            end
            if (n == 101) busA.wr_valid = 1'b0;
            if (n == 1000) busA.clear_req = 1'b1;
            if (n == 1001) busA.clear_req = 1'b0;
            @(negedge clk);
        end
        checkVal("clearSweepLen", n, NCELL);
        clearModel();
        readExpect("cornerAfterClear", 639, 479);
        readExpect("cell52AfterClear", 40, 20);

        doWrite(10, 10, 'h2B);
        busA.clear_req = 1'b1;
        @(negedge clk);
        busA.clear_req = 1'b0;
        repeat (1000) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        countBusy(n);
        checkVal("midResetSweepLen", n, NCELL);
        clearModel();
        readExpect("afterMidReset", 80, 100);

        busB.xcoor = 10'(8);
        busB.ycoor = 9'(400);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rows40Blank", int'(busB.char_out), BLANK);
        checkVal("rows40CellX", int'(busB.cell_x), 0);
        checkVal("rows40CellY", int'(busB.cell_y), 0);
        busB.xcoor = 10'(639);
        busB.ycoor = 9'(399);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rows40LastRow", int'(busB.char_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
